err_flag_arbiter: RTL
=====================

# err_flag_arbiter

Collects per-lane error-detect pulses from the error-correcting arithmetic lanes, holds them in sticky pending flags, and shares the single correction engine between lanes by round-robin. It presents one lane index at a time over a req/ack handshake and publishes a registered any-error summary flag. It sits between the lane detectors and the correction engine inside the TPU array.

## Interface
- NUM_LANES, 4, number of requesting lanes (2..16)
- LANE_W, $clog2(NUM_LANES), lane index width
- CNT_W, 16, width of serviced-event counter
- TIMEOUT_CYCLES, 64, ack watchdog limit (used only with ERR_ARB_TIMEOUT_EN)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- err_in  in  NUM_LANES  per-lane error pulse, any width, sampled every edge
- corr_ack  in  1  correction engine accepted/finished current lane
- corr_req  out  1  request to correction engine, held until ack
- corr_lane  out  LANE_W  lane being serviced, stable while corr_req=1
- any_err  out  1  registered OR of pend_vec
- pend_vec  out  NUM_LANES  sticky pending flags
- svc_cnt  out  CNT_W  saturating count of completed services
- timeout_flag  out  1  sticky watchdog flag (constant 0 without macro)

## Operation
- Reset: pend_vec=0, any_err=0, corr_req=0, corr_lane=0, svc_cnt=0, timeout_flag=0, rr pointer=0, state IDLE.
- Pending: each edge pend[i] <= pend[i] | err_in[i], except clear of the serviced lane (below).
- any_err <= |pend_vec (one extra register stage).
- FSM states IDLE, REQ.
  - IDLE: if pend_vec!=0, pick first set bit searching from ptr upward with wrap; load corr_lane, corr_req<=1, go REQ. Else stay.
  - REQ: hold corr_req/corr_lane. On corr_ack=1: clear pend[corr_lane], corr_req<=0, ptr<=corr_lane+1 (wrap to 0 at NUM_LANES), svc_cnt+1 (saturate at all-ones), go IDLE.
- corr_ack in IDLE is ignored.
- Simultaneous err_in on lane being cleared: set wins; pend stays 1 and lane is re-serviced in later rotation.
- Multiple pending: strict round-robin; no lane serviced twice while another is pending.
- Reset asserted mid-REQ: all state cleared immediately (async); corr_req drops without ack.

## Timing
- err_in high before edge t -> pend set after t -> any_err after t+1.
- IDLE with pending at edge t -> corr_req=1 after t.
- corr_ack sampled at edge k -> corr_req=0, pend cleared after k; earliest next corr_req after k+1 (one idle cycle between grants).
- Service throughput: max one lane per 2 cycles with zero-wait ack.

## Configuration
- ERR_ARB_TIMEOUT_EN defined: counter runs in REQ, resets on entry; reaching TIMEOUT_CYCLES without ack -> timeout_flag<=1 (sticky until rst), corr_req<=0, pend of that lane kept, ptr advances past it, svc_cnt unchanged, go IDLE.
- Not defined: no counter; REQ waits indefinitely; timeout_flag tied 0.

## Structure
- Package err_arb_pkg: state enum (IDLE, REQ), lane-width helper function, default TIMEOUT_CYCLES constant.
- One sub-module rr_pick: combinational round-robin picker (req vector, ptr -> grant index, valid).

## Test plan
- Single: err_in=4'b0100 one cycle -> pend_vec=0100, any_err next cycle, corr_req with corr_lane=2; ack -> pend_vec=0, svc_cnt=1.
- Round-robin: err_in=4'b1111, immediate acks -> corr_lane sequence 0,1,2,3, svc_cnt=4, any_err falls after last clear.
- Collision: err_in[1] pulses on same edge as ack for lane 1 -> pend[1] stays 1, lane 1 re-granted after others.
- Reset mid-REQ: rst during corr_req=1 -> all outputs 0 asynchronously, no grant after rst release until new err_in.
- Saturation: CNT_W=4, 20 services -> svc_cnt holds 15.
- Timeout (macro on, TIMEOUT_CYCLES=8): pend lane 0, never ack -> timeout_flag=1 after 8 REQ cycles, corr_req=0, pend[0] still 1, next grant selects lane 1 if pending else lane 0.

Source files
------------

// File: rtl/err_arb_pkg.sv
// Shared types and constants for the error-flag arbiter slice.
package err_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } arb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  // Lane index width; never narrower than one bit.
  function automatic int unsigned lane_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/err_flag_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_pick #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned LANE_W    = 2
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [LANE_W-1:0]    ptr_i,
  output logic [LANE_W-1:0]    grant_o,
  output logic                 valid_o
);

  logic [LANE_W:0]   sum;
  logic [LANE_W-1:0] idx;
  logic              found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      // ptr_i and k are both below NUM_LANES, so one subtraction wraps the sum.
      sum = {1'b0, ptr_i} + (LANE_W+1)'(k);
      if (sum >= (LANE_W+1)'(NUM_LANES)) sum = sum - (LANE_W+1)'(NUM_LANES);
      idx = sum[LANE_W-1:0];
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        grant_o = idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/err_flag_arbiter.sv
// Sticky per-lane error flags shared round-robin onto one correction engine.
// Optional ack watchdog enabled by defining ERR_ARB_TIMEOUT_EN.
module err_flag_arbiter
  import err_arb_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned LANE_W         = lane_w(NUM_LANES),
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] err_in,
  input  logic                 corr_ack,
  output logic                 corr_req,
  output logic [LANE_W-1:0]    corr_lane,
  output logic                 any_err,
  output logic [NUM_LANES-1:0] pend_vec,
  output logic [CNT_W-1:0]     svc_cnt,
  output logic                 timeout_flag
);

  if (NUM_LANES < 2 || NUM_LANES > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("err_flag_arbiter: NUM_LANES must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_e           state_q, state_d;
  logic [NUM_LANES-1:0] pend_q, pend_d, clr_mask;
  logic                 any_err_q, any_err_d;
  logic                 req_q, req_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [LANE_W-1:0]    ptr_q, ptr_d, nxt_ptr;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LANE_W-1:0]    pick_lane;
  logic                 pick_valid;
  logic                 tmo_hit;

  rr_pick #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_rr_pick (
    .req_i   (pend_q),
    .ptr_i   (ptr_q),
    .grant_o (pick_lane),
    .valid_o (pick_valid)
  );

`ifdef ERR_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tflag_q;

  // Counter is held at zero outside REQ, so it restarts on every grant.
  assign tmo_d   = (state_q == REQ) ? tmo_q + 1'b1 : '0;
  assign tmo_hit = (state_q == REQ) && !corr_ack && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      tflag_q <= tflag_q | tmo_hit;
    end
  end

  assign timeout_flag = tflag_q;
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign nxt_ptr = (lane_q == LANE_W'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    lane_d   = lane_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    clr_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          lane_d  = pick_lane;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (corr_ack) begin
          clr_mask[lane_q] = 1'b1;
          req_d            = 1'b0;
          ptr_d            = nxt_ptr;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d          = IDLE;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new pulse on the lane being cleared wins over the clear.
    pend_d    = (pend_q & ~clr_mask) | err_in;
    any_err_d = |pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      any_err_q <= 1'b0;
      req_q     <= 1'b0;
      lane_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      any_err_q <= any_err_d;
      req_q     <= req_d;
      lane_q    <= lane_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign corr_req  = req_q;
  assign corr_lane = lane_q;
  assign any_err   = any_err_q;
  assign pend_vec  = pend_q;
  assign svc_cnt   = cnt_q;

endmodule
